// File: rtl/timer.sv
`default_nettype none
// ============================================================================
//  Module      : timer
//  Description : 8-bit up/down timer with reload register, 4-bit prescaler,
//                sticky overflow/underflow flags and a zero-wait APB slave.
//  Revision    : 1.0  initial release
// ============================================================================
module timer (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [7:0] paddr,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pready,
    output logic       pslverr,
    output logic       tmr_ovf,
    output logic       tmr_udf
);

    localparam logic [7:0] ADDR_TDR  = 8'h00;
    localparam logic [7:0] ADDR_TCR  = 8'h01;
    localparam logic [7:0] ADDR_TSR  = 8'h02;
    localparam logic [7:0] ADDR_TCNT = 8'h03;
    // Implemented TCR bits: load[7], dir[5], en[4], cks[1:0]
    localparam logic [7:0] TCR_MASK  = 8'hB3;

    logic [7:0] tdr_q,  tdr_d;
    logic [7:0] tcr_q,  tcr_d;
    logic [7:0] tcnt_q, tcnt_d;
    logic [3:0] div_q,  div_d;
    logic       ovf_q,  ovf_d;
    logic       udf_q,  udf_d;

    logic       wr_en;
    logic       ctl_load;
    logic       ctl_dir;
    logic       ctl_en;
    logic [1:0] ctl_cks;
    logic       div_full;
    logic       tick;
    logic       ovf_set;
    logic       udf_set;

    assign wr_en    = psel & penable & pwrite;
    assign ctl_load = tcr_q[7];
    assign ctl_dir  = tcr_q[5];
    assign ctl_en   = tcr_q[4];
    assign ctl_cks  = tcr_q[1:0];

    assign pready   = psel & penable;
    assign pslverr  = 1'b0;

    // Flags are forced low on the pins while reset is held
    assign tmr_ovf  = ovf_q & sys_rst_n;
    assign tmr_udf  = udf_q & sys_rst_n;

    // Prescaler terminal condition: div[cks:0] all ones, cks sampled live
    always_comb begin
        div_full = 1'b0;
        case (ctl_cks)
            2'b00:   div_full = div_q[0];
            2'b01:   div_full = &div_q[1:0];
            2'b10:   div_full = &div_q[2:0];
            default: div_full = &div_q;
        endcase
    end

    // Prescaler, count tick and wrap detection
    always_comb begin
        tick    = ctl_en & ~ctl_load & div_full;
        div_d   = (ctl_en && !ctl_load) ? div_q + 4'd1 : 4'd0;
        udf_set = tick &  ctl_dir & (tcnt_q == 8'h00);
        ovf_set = tick & ~ctl_dir & (tcnt_q == 8'hFF);
        tcnt_d  = tcnt_q;
        if (ctl_load) begin
            tcnt_d = tdr_q;
        end else if (tick) begin
            tcnt_d = ctl_dir ? tcnt_q - 8'd1 : tcnt_q + 8'd1;
        end
    end

    // Register writes; a flag set on the same edge as a clearing write wins
    always_comb begin
        tdr_d = tdr_q;
        tcr_d = tcr_q;
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (wr_en && paddr == ADDR_TDR) begin
            tdr_d = pwdata;
        end
        if (wr_en && paddr == ADDR_TCR) begin
            tcr_d = pwdata & TCR_MASK;
        end
        if (wr_en && paddr == ADDR_TSR) begin
            ovf_d = ovf_q & pwdata[0];
            udf_d = udf_q & pwdata[1];
        end
        ovf_d = ovf_d | ovf_set;
        udf_d = udf_d | udf_set;
    end

    // Combinational read mux, quiet outside reads and during reset
    always_comb begin
        prdata = 8'h00;
        if (sys_rst_n && psel && !pwrite) begin
            case (paddr)
                ADDR_TDR:  prdata = tdr_q;
                ADDR_TCR:  prdata = tcr_q;
                ADDR_TSR:  prdata = {6'b000000, udf_q, ovf_q};
                ADDR_TCNT: prdata = tcnt_q;
                default:   prdata = 8'h00;
            endcase
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            tdr_q  <= 8'h00;
            tcr_q  <= 8'h00;
            tcnt_q <= 8'h00;
            div_q  <= 4'd0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            tdr_q  <= tdr_d;
            tcr_q  <= tcr_d;
            tcnt_q <= tcnt_d;
            div_q  <= div_d;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer
//  Description : Self-checking bench for the timer block.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_timer;

    localparam logic [7:0] A_TDR  = 8'h00;
    localparam logic [7:0] A_TCR  = 8'h01;
    localparam logic [7:0] A_TSR  = 8'h02;
    localparam logic [7:0] A_TCNT = 8'h03;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       psel = 1'b0;
    logic       penable = 1'b0;
    logic       pwrite = 1'b0;
    logic [7:0] paddr = 8'h00;
    logic [7:0] pwdata = 8'h00;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;
    logic       tmr_ovf;
    logic       tmr_udf;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got;
    logic [7:0] exp;
    logic       rdy_s;
    logic       err_s;

    timer dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .tmr_ovf   (tmr_ovf),
        .tmr_udf   (tmr_udf)
    );

    always #5 sys_clk = ~sys_clk;

    // Two-phase APB write; write lands on the second rising edge
    task automatic apb_write(input logic [7:0] a, input logic [7:0] d,
                             output logic rdy, output logic err);
        @(negedge sys_clk);
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
        @(posedge sys_clk);
        #1 penable = 1'b1;
        #1 rdy = pready; err = pslverr;
        @(posedge sys_clk);
        #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    // Combinational read without consuming a clock edge
    task automatic peek(input logic [7:0] a, output logic [7:0] d);
        paddr = a; pwrite = 1'b0; penable = 1'b0; psel = 1'b1;
        #1 d = prdata;
        psel = 1'b0;
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset;
        // Write attempted while reset is held must be dropped
        apb_write(A_TDR, 8'h55, rdy_s, err_s);
        exp_q.push_back(8'h00); peek(A_TDR, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL rst_hold_prdata: got %02h exp %02h", got, exp); end
        @(negedge sys_clk); sys_rst_n = 1'b1;
        wait_clks(1);
        for (int i = 0; i < 5; i++) begin
            logic [7:0] a;
            a = (i == 4) ? 8'h10 : 8'(i);
            exp_q.push_back(8'h00); peek(a, got); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL reset_reg_%02h: got %02h exp %02h", a, got, exp); end
        end
        exp_q.push_back(8'h00); got = {6'b0, tmr_udf, tmr_ovf}; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_flags: got %02h exp %02h", got, exp); end
    endtask

    task automatic test_regs;
        apb_write(A_TDR, 8'hA5, rdy_s, err_s);
        exp_q.push_back(8'h01); got = {6'b0, err_s, rdy_s}; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL apb_ready_err: got %02h exp %02h", got, exp); end
        exp_q.push_back(8'h00); paddr = A_TDR; psel = 1'b1; #1 got = {7'b0, pready}; psel = 1'b0; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL pready_setup: got %02h exp %02h", got, exp); end
        exp_q.push_back(8'hA5); peek(A_TDR, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL tdr_rw: got %02h exp %02h", got, exp); end
        apb_write(A_TCR, 8'hFF, rdy_s, err_s);
        exp_q.push_back(8'hB3); peek(A_TCR, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL tcr_mask: got %02h exp %02h", got, exp); end
        apb_write(A_TCR, 8'h00, rdy_s, err_s);
        apb_write(A_TDR, 8'h3C, rdy_s, err_s);
        apb_write(8'h04, 8'h77, rdy_s, err_s);
        exp_q.push_back(8'hA5); peek(A_TCNT, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL tdr_no_tcnt: got %02h exp %02h", got, exp); end
        exp_q.push_back(8'h00); peek(8'h04, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL unmapped: got %02h exp %02h", got, exp); end
    endtask

    task automatic test_down_udf;
        apb_write(A_TDR, 8'h0A, rdy_s, err_s);
        apb_write(A_TCR, 8'h80, rdy_s, err_s);
        apb_write(A_TCR, 8'h30, rdy_s, err_s);
        wait_clks(11);
        exp_q.push_back(8'h00); got = {7'b0, tmr_udf}; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL udf_at_11: got %02h exp %02h", got, exp); end
        wait_clks(11);
        exp_q.push_back(8'h01); got = {7'b0, tmr_udf}; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL udf_at_22: got %02h exp %02h", got, exp); end
        exp_q.push_back(8'hFF); peek(A_TCNT, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL tcnt_at_22: got %02h exp %02h", got, exp); end
        exp_q.push_back(8'h02); peek(A_TSR, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL tsr_at_22: got %02h exp %02h", got, exp); end
        wait_clks(2);
        exp_q.push_back(8'hFE); peek(A_TCNT, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL tcnt_after_wrap: got %02h exp %02h", got, exp); end
        exp_q.push_back(8'h01); got = {7'b0, tmr_udf}; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL udf_sticky: got %02h exp %02h", got, exp); end
    endtask

    task automatic test_clear;
        apb_write(A_TSR, 8'h02, rdy_s, err_s);
        exp_q.push_back(8'h02); peek(A_TSR, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL tsr_write1_keep: got %02h exp %02h", got, exp); end
        apb_write(A_TSR, 8'h00, rdy_s, err_s);
        exp_q.push_back(8'h00); peek(A_TSR, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL tsr_clear: got %02h exp %02h", got, exp); end
        exp_q.push_back(8'h00); got = {7'b0, tmr_udf}; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL udf_pin_clear: got %02h exp %02h", got, exp); end
        apb_write(A_TCR, 8'h00, rdy_s, err_s);
    endtask

    task automatic test_set_wins;
        apb_write(A_TDR, 8'h00, rdy_s, err_s);
        apb_write(A_TCR, 8'h80, rdy_s, err_s);
        apb_write(A_TCR, 8'h30, rdy_s, err_s);
        // Clearing write lands on the same edge as the 0x00->0xFF tick
        apb_write(A_TSR, 8'h00, rdy_s, err_s);
        exp_q.push_back(8'h01); got = {7'b0, tmr_udf}; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL set_wins: got %02h exp %02h", got, exp); end
        exp_q.push_back(8'hFF); peek(A_TCNT, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL set_wins_tcnt: got %02h exp %02h", got, exp); end
        apb_write(A_TCR, 8'h00, rdy_s, err_s);
        apb_write(A_TSR, 8'h00, rdy_s, err_s);
    endtask

    task automatic test_long_wrap;
        apb_write(A_TDR, 8'hFF, rdy_s, err_s);
        apb_write(A_TCR, 8'h80, rdy_s, err_s);
        apb_write(A_TCR, 8'h30, rdy_s, err_s);
        wait_clks(511);
        exp_q.push_back(8'h00); got = {7'b0, tmr_udf}; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL udf_at_511: got %02h exp %02h", got, exp); end
        wait_clks(1);
        exp_q.push_back(8'h01); got = {7'b0, tmr_udf}; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL udf_at_512: got %02h exp %02h", got, exp); end
        apb_write(A_TCR, 8'h00, rdy_s, err_s);
        apb_write(A_TSR, 8'h00, rdy_s, err_s);
    endtask

    task automatic test_cks_change;
        apb_write(A_TDR, 8'h00, rdy_s, err_s);
        apb_write(A_TCR, 8'h80, rdy_s, err_s);
        apb_write(A_TCR, 8'h10, rdy_s, err_s);
        // Switch to divide-by-4 two clocks in; div keeps running
        apb_write(A_TCR, 8'h11, rdy_s, err_s);
        wait_clks(3);
        exp_q.push_back(8'h02); peek(A_TCNT, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL cks_change_5: got %02h exp %02h", got, exp); end
        wait_clks(3);
        exp_q.push_back(8'h03); peek(A_TCNT, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL cks_change_8: got %02h exp %02h", got, exp); end
        apb_write(A_TCR, 8'h00, rdy_s, err_s);
    endtask

    task automatic test_up_ovf;
        apb_write(A_TDR, 8'hFE, rdy_s, err_s);
        apb_write(A_TCR, 8'h80, rdy_s, err_s);
        apb_write(A_TCR, 8'h13, rdy_s, err_s);
        wait_clks(31);
        exp_q.push_back(8'h00); got = {7'b0, tmr_ovf}; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL ovf_at_31: got %02h exp %02h", got, exp); end
        wait_clks(1);
        exp_q.push_back(8'h01); got = {7'b0, tmr_ovf}; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL ovf_at_32: got %02h exp %02h", got, exp); end
        exp_q.push_back(8'h00); peek(A_TCNT, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL tcnt_at_32: got %02h exp %02h", got, exp); end
    endtask

    task automatic test_reset_gating;
        // Flags and read data are masked as soon as reset is asserted
        @(negedge sys_clk); sys_rst_n = 1'b0;
        #1;
        exp_q.push_back(8'h00); got = {7'b0, tmr_ovf}; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL rst_ovf_pin: got %02h exp %02h", got, exp); end
        exp_q.push_back(8'h00); peek(A_TCR, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL rst_prdata: got %02h exp %02h", got, exp); end
        wait_clks(1);
        @(negedge sys_clk); sys_rst_n = 1'b1;
        wait_clks(1);
        exp_q.push_back(8'h00); peek(A_TSR, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL post_rst_tsr: got %02h exp %02h", got, exp); end
        exp_q.push_back(8'h00); peek(A_TCR, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL post_rst_tcr: got %02h exp %02h", got, exp); end
    endtask

    task automatic test_reset_midcount;
        apb_write(A_TDR, 8'hC8, rdy_s, err_s);
        apb_write(A_TCR, 8'h80, rdy_s, err_s);
        apb_write(A_TCR, 8'h30, rdy_s, err_s);
        wait_clks(201);
        @(negedge sys_clk); sys_rst_n = 1'b0;
        wait_clks(1);
        @(negedge sys_clk); sys_rst_n = 1'b1;
        wait_clks(1);
        exp_q.push_back(8'h00); peek(A_TCNT, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL midcount_tcnt: got %02h exp %02h", got, exp); end
        exp_q.push_back(8'h00); peek(A_TDR, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL midcount_tdr: got %02h exp %02h", got, exp); end
        apb_write(A_TDR, 8'h14, rdy_s, err_s);
        apb_write(A_TCR, 8'h80, rdy_s, err_s);
        apb_write(A_TCR, 8'h30, rdy_s, err_s);
        wait_clks(21);
        exp_q.push_back(8'h00); got = {7'b0, tmr_udf}; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL restart_udf_21: got %02h exp %02h", got, exp); end
        wait_clks(21);
        exp_q.push_back(8'h01); got = {7'b0, tmr_udf}; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL restart_udf_42: got %02h exp %02h", got, exp); end
    endtask

    initial begin
        wait_clks(2);
        test_reset();
        test_regs();
        test_down_udf();
        test_clear();
        test_set_wins();
        test_long_wrap();
        test_cks_change();
        test_up_ovf();
        test_reset_gating();
        test_reset_midcount();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/timer.md
TIMER -- requirements
Module: timer

Interface
REQ-001 The module SHALL have one clock and a reset that is synchronous and active-low; ports are named as the codebase does (sys_clk, sys_rst_n).
REQ-002 sys_clk  input  1  system/APB clock; all state updates on its rising edge.
REQ-003 sys_rst_n  input  1  synchronous active-low reset.
REQ-004 psel  input  1  APB select.
REQ-005 penable  input  1  APB access phase.
REQ-006 pwrite  input  1  1 = write, 0 = read.
REQ-007 paddr  input  8  register address.
REQ-008 pwdata  input  8  write data.
REQ-009 prdata  output  8  read data.
REQ-010 pready  output  1  transfer complete.
REQ-011 pslverr  output  1  transfer error.
REQ-012 tmr_ovf  output  1  level copy of TSR.OVF.
REQ-013 tmr_udf  output  1  level copy of TSR.UDF.

Function
REQ-014 Register map SHALL be: 0x00 TDR (RW, 8-bit reload value); 0x01 TCR (RW); 0x02 TSR (status); 0x03 TCNT (RO, counter value); other addresses read 0x00, writes ignored.
REQ-015 TCR bits SHALL be: [7] load, [5] dir (1 = down, 0 = up), [4] en, [1:0] cks; bits 6,3,2 read 0 and ignore writes.
REQ-016 TSR bits SHALL be: [0] OVF, [1] UDF; bits 7:2 read 0.
REQ-017 APB SHALL be zero-wait-state: pready = 1 whenever psel & penable; pslverr SHALL always be 0.
REQ-018 A write SHALL take effect on the sys_clk edge where psel & penable & pwrite = 1.
REQ-019 prdata SHALL be combinational from paddr when psel & !pwrite, else 0x00.
REQ-020 While TCR.load = 1, TCNT SHALL be loaded with TDR on every clock; counting and divider are held.
REQ-021 A 4-bit prescaler div SHALL be cleared while en = 0 or load = 1, and otherwise increment every clock, wrapping.
REQ-022 A count tick SHALL occur on clocks where en = 1, load = 0 and div[cks:0] are all ones, giving one tick every 2, 4, 8, 16 clocks for cks = 00, 01, 10, 11.
REQ-023 On a tick, TCNT SHALL decrement if dir = 1 and increment if dir = 0, modulo 256.
REQ-024 With en set and cks = 00, the first tick SHALL occur 2 clocks after the en write edge; from TCNT = N counting down, the wrap 0x00->0xFF SHALL occur 2N+2 clocks after the en write edge.
REQ-025 UDF SHALL be set on the same edge as a tick that changes TCNT from 0x00 to 0xFF while counting down.
REQ-026 OVF SHALL be set on the same edge as a tick that changes TCNT from 0xFF to 0x00 while counting up.
REQ-027 Flags SHALL be sticky: counting continues after wrap, and a flag SHALL remain set until cleared.
REQ-028 Writing 0 to a TSR flag bit SHALL clear that flag; writing 1 SHALL leave it unchanged.
REQ-029 If a flag set event and a clearing write occur on the same edge, the set SHALL win.
REQ-030 A TDR write SHALL NOT affect TCNT until load is asserted.
REQ-031 Changing cks while counting SHALL take effect immediately, with no reset of div.

Reset
REQ-032 When sys_rst_n = 0 at a clock edge, TDR, TCR, TSR, TCNT and div SHALL become 0x00/0, stopping any count in progress.
REQ-033 While reset is active, APB writes SHALL be ignored, and prdata, tmr_ovf and tmr_udf SHALL read 0.
REQ-034 After reset deasserts, the block SHALL behave identically to power-up, with no residue of the prior count.

Verification
REQ-035 Scenario: read TDR after reset -> 0x00; read TCR, TSR and TCNT -> 0x00.
REQ-036 Scenario: TDR = 0x0A, TCR = 0x80, then TCR = 0x30 (down, cks = 00):
- at 11 clocks after the en write, TSR.UDF = 0;
- at 22 clocks after the en write, TSR.UDF = 1 and TCNT = 0xFF.
REQ-037 Scenario: TDR = 0xC8, load, count down; reset after 201 clocks; load TDR = 0x14 and count down:
- UDF = 0 after 21 clocks;
- UDF = 1 after 42 clocks.
REQ-038 Scenario: TDR = 0xFE, load, TCR = 0x13 (up, cks = 11):
- OVF = 0 after 31 clocks;
- OVF = 1 and TCNT = 0x00 after 32 clocks.
REQ-039 Scenario: with UDF set, write TSR = 0x00 -> TSR reads 0x00 and tmr_udf = 0.
REQ-040 Scenario: TDR = 0xFF, load, cks = 00 down, N = 255 -> UDF = 1 exactly 512 clocks after the en write, and not at 511.
